// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids,
// and the wait-state counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    LDR = 1'b1
  } req_id_t;

  // Bits needed to hold max(read_lat, write_lat) - 1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned read_lat,
                                            input int unsigned write_lat);
    int unsigned m;
    m = (read_lat > write_lat) ? read_lat : write_lat;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the memory port arbiter.
// slave: the arbiter itself; master: requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [1:0]        state_o;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_ack, ldr_ack, rdata,
    output mem_addr, mem_wdata, mem_wr,
    output busy, state_o
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_ack, ldr_ack, rdata,
    input  mem_addr, mem_wdata, mem_wr,
    input  busy, state_o
  );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Down-counter for memory wait states: loadable, decrements on request,
// flags zero.
module wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Count register; load takes priority over decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Zero flag ends the wait phase of an access.
  always_comb begin
    zero = (cnt == '0);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between the CPU and the loader with
// round-robin on ties, and owns the memory read/write wait states.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(READ_LAT, WRITE_LAT);

  state_t            state;
  state_t            state_nx;
  req_id_t           last_grant;
  req_id_t           grant_id;
  logic              grant;
  logic              grant_we;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;

  // Pick a winner in IDLE: a lone request wins, a tie goes to the requester
  // that was not granted last time.
  always_comb begin
    grant    = (state == IDLE) && (bus.cpu_req || bus.ldr_req);
    grant_id = CPU;
    if (bus.cpu_req && bus.ldr_req) begin
      grant_id = (last_grant == CPU) ? LDR : CPU;
    end else if (bus.ldr_req) begin
      grant_id = LDR;
    end
    grant_we     = (grant_id == CPU) ? bus.cpu_we : bus.ldr_we;
    cnt_load     = grant;
    cnt_load_val = grant_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
    cnt_dec      = (state == BUSY) && !cnt_zero;
  end

  wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: DONE always returns to IDLE without looking at requests.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = BUSY;
      BUSY:    if (cnt_zero) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the winner's request at grant; last_grant doubles as the id of
  // the access in flight, since it only changes at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= LDR;
      lat_we     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (grant) begin
      last_grant <= grant_id;
      lat_we     <= grant_we;
      lat_addr   <= (grant_id == CPU) ? bus.cpu_addr  : bus.ldr_addr;
      lat_wdata  <= (grant_id == CPU) ? bus.cpu_wdata : bus.ldr_wdata;
    end
  end

  // Read data is taken on the last wait cycle and held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if ((state == BUSY) && cnt_zero && !lat_we) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // Outputs: ack for the owner in DONE, write strobe only while BUSY.
  always_comb begin
    bus.cpu_ack   = (state == DONE) && (last_grant == CPU);
    bus.ldr_ack   = (state == DONE) && (last_grant == LDR);
    bus.mem_wr    = (state == BUSY) && lat_we;
    bus.mem_addr  = lat_addr;
    bus.mem_wdata = lat_wdata;
    bus.rdata     = rdata_q;
    bus.busy      = (state != IDLE);
    bus.state_o   = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic
// from both requesters, checked cycle by cycle against a timeline model.
module tb_mem_port_arbiter;

  localparam int RL = 2;
  localparam int WL = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .READ_LAT (RL),
    .WRITE_LAT(WL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [31:0] init_val(input int unsigned a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'hC3A50F1E);
  endfunction

  // Memory: writes land on the clock edge, reads arrive RL-1 registers late
  // so data is valid RL cycles after the address.
  bit          env_valid [256];
  logic [31:0] env_data  [256];
  logic [31:0] pipe;
  logic [7:0]  ea;
  assign ea = bus.mem_addr[7:0];
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      env_valid[ea] <= 1'b1;
      env_data[ea]  <= bus.mem_wdata;
    end
    pipe <= env_valid[ea] ? env_data[ea] : init_val(32'(ea));
  end
  assign bus.mem_rdata = pipe;

  // Model: each access is granted at edge t_g, is BUSY for lat_c cycles,
  // DONE for one, then idle.
  logic [31:0] mmem [256];
  int          n      = 0;
  int          t_g    = -100;
  bit          act    = 1'b0;
  int          lat_c  = 1;
  int          w      = 0;
  int          last_g = 1;
  bit          w_we   = 1'b0;
  logic [31:0] w_addr  = '0;
  logic [31:0] w_wdata = '0;
  logic [31:0] rdata_e = '0;
  int          mode   = 0;
  int          wr_cnt = 0;
  int          ack_log[$];
  int          cpu_ack_cyc[$];

  function automatic int phase();
    int d;
    if (!act) return 0;
    d = n - t_g;
    if (d < lat_c) return 1;
    if (d == lat_c) return 2;
    return 0;
  endfunction

  function automatic bit req_of(input int who);
    return (who == 0) ? bus.cpu_req : bus.ldr_req;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 255));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_miss++;
    $error("FAIL %s observed=no_ack expected=ack_within_bound", tag);
  endtask

  task automatic issue(input int who, input bit we, input logic [31:0] addr,
                       input logic [31:0] data);
    if (who == 0) begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data; bus.cpu_req = 1'b1;
    end else begin
      bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = data; bus.ldr_req = 1'b1;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) bus.cpu_req = 1'b0;
    else          bus.ldr_req = 1'b0;
  endtask

  task automatic model_edge();
    bit prev_idle;
    if (act && (n - t_g) == lat_c) begin
      if (w_we) mmem[w_addr[7:0]] = w_wdata;
      else      rdata_e = mmem[w_addr[7:0]];
    end
    prev_idle = !act || ((n - 1 - t_g) > lat_c);
    if (prev_idle && (bus.cpu_req || bus.ldr_req)) begin
      if (bus.cpu_req && bus.ldr_req) w = 1 - last_g;
      else                            w = bus.cpu_req ? 0 : 1;
      last_g  = w;
      act     = 1'b1;
      t_g     = n;
      w_we    = (w == 0) ? bus.cpu_we    : bus.ldr_we;
      w_addr  = (w == 0) ? bus.cpu_addr  : bus.ldr_addr;
      w_wdata = (w == 0) ? bus.cpu_wdata : bus.ldr_wdata;
      lat_c   = w_we ? WL : RL;
    end
  endtask

  task automatic model_reset();
    act = 1'b0; t_g = -100; last_g = 1; w_we = 1'b0;
    w_addr = '0; w_wdata = '0; rdata_e = '0;
  endtask

  task automatic check_outputs();
    int p;
    p = phase();
    chk("state_o",   32'(bus.state_o), 32'(p));
    chk("busy",      32'(bus.busy),    32'(p != 0));
    chk("cpu_ack",   32'(bus.cpu_ack), 32'(p == 2 && w == 0));
    chk("ldr_ack",   32'(bus.ldr_ack), 32'(p == 2 && w == 1));
    chk("ack_excl",  32'(bus.cpu_ack && bus.ldr_ack), 32'(0));
    chk("mem_wr",    32'(bus.mem_wr),  32'(p == 1 && w_we));
    chk("mem_addr",  bus.mem_addr,  w_addr);
    chk("mem_wdata", bus.mem_wdata, w_wdata);
    chk("rdata",     bus.rdata,     rdata_e);
  endtask

  task automatic on_ack(input int who);
    case (mode)
      0: drop(who);
      1: if (req_of(who)) issue(who, 1'b0, rand_addr(), $urandom());
      default: begin
        if ($urandom_range(0, 1) == 1)
          issue(who, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        else
          drop(who);
      end
    endcase
  endtask

  task automatic random_drive();
    bit mine;
    for (int who = 0; who < 2; who++) begin
      mine = act && (w == who) && (phase() != 0);
      if (!req_of(who) && !mine) begin
        if ($urandom_range(0, 3) == 0)
          issue(who, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      end else if (mine && phase() == 1) begin
        // Inputs changing mid-access must not affect the access in flight.
        if ($urandom_range(0, 5) == 0)
          issue(who, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        if ($urandom_range(0, 9) == 0) drop(who);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    model_edge();
    check_outputs();
    if (bus.mem_wr) wr_cnt++;
    if (bus.cpu_ack) begin
      ack_log.push_back(0);
      cpu_ack_cyc.push_back(n);
    end
    if (bus.ldr_ack) ack_log.push_back(1);
    if (phase() == 2) on_ack(w);
    if (mode == 2) random_drive();
  endtask

  task automatic wait_ack(input int who, input string tag);
    for (int i = 0; i < 40; i++) begin
      step();
      if ((who == 0) ? bus.cpu_ack : bus.ldr_ack) return;
    end
    timeout(tag);
  endtask

  task automatic settle();
    mode = 0;
    drop(0);
    drop(1);
    repeat (RL + 4) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = init_val(32'(i));
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;

    // Reset state.
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // CPU read of 0x10.
    mode = 0;
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_ack(0, "t1_ack");
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);

    // Loader write of 0x1234 to 0x20, then read it back.
    wr_cnt = 0;
    issue(1, 1'b1, 32'h20, 32'h1234);
    wait_ack(1, "t2_ack");
    chk("t2_wr_cycles", 32'(wr_cnt), 32'(WL));
    issue(1, 1'b0, 32'h20, 32'h0);
    wait_ack(1, "t2_rd_ack");
    chk("t2_rdata", bus.rdata, 32'h1234);

    // Both requesting continuously: strict alternation starting with CPU.
    ack_log.delete();
    mode = 1;
    issue(0, 1'b0, rand_addr(), 32'h0);
    issue(1, 1'b0, rand_addr(), 32'h0);
    for (int i = 0; i < 80 && ack_log.size() < 4; i++) step();
    if (ack_log.size() < 4) timeout("t3_acks");
    for (int i = 0; i < 4; i++)
      chk("t3_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'd9, 32'(i % 2));
    settle();

    // CPU holding req across acks: back-to-back reads spaced RL+2 cycles.
    cpu_ack_cyc.delete();
    mode = 1;
    issue(0, 1'b0, rand_addr(), 32'h0);
    for (int i = 0; i < 60 && cpu_ack_cyc.size() < 3; i++) step();
    if (cpu_ack_cyc.size() < 3) timeout("t4_acks");
    else begin
      chk("t4_gap0", 32'(cpu_ack_cyc[1] - cpu_ack_cyc[0]), 32'(RL + 2));
      chk("t4_gap1", 32'(cpu_ack_cyc[2] - cpu_ack_cyc[1]), 32'(RL + 2));
    end
    settle();

    // CPU address/op changed after grant: access uses the granted request.
    issue(0, 1'b0, 32'h10, 32'h0);
    step();
    bus.cpu_addr  = 32'h20;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = 32'h5555AAAA;
    wait_ack(0, "t6_ack");
    chk("t6_rdata", bus.rdata, mmem[8'h10]);
    drop(0);
    settle();

    // Reset in the middle of a loader write.
    issue(1, 1'b1, 32'h30, 32'hCAFE);
    step();
    #2 reset = 1'b1;
    #1;
    chk("t5_mem_wr", 32'(bus.mem_wr),  32'd0);
    chk("t5_busy",   32'(bus.busy),    32'd0);
    chk("t5_state",  32'(bus.state_o), 32'd0);
    chk("t5_ldrack", 32'(bus.ldr_ack), 32'd0);
    model_reset();
    issue(0, 1'b0, rand_addr(), 32'h0);
    @(negedge clk);
    n++;
    check_outputs();
    reset = 1'b0;
    ack_log.delete();
    wait_ack(0, "t5_cpu_ack");
    chk("t5_first", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'd9, 32'd0);
    wait_ack(1, "t5_ldr_ack");
    settle();

    // Random traffic from both requesters.
    mode = 2;
    repeat (1500) step();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
